// File: rtl/fsk_pkg.sv
// Shared types and constants for the FSK transmit path.
// Symbol levels match what the FSK_modulator benches use.
package fsk_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int   CNT_W = 16;
  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

endpackage

// File: rtl/fsk_tx_sequencer_if.sv
// Byte valid/ready channel into the FSK frame sequencer.
// Master offers bytes; slave accepts them.
interface fsk_tx_sequencer_if #(
  parameter int DW = 8
);

  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/fsk_bit_timer.sv
// Symbol timer: counts 0..BIT_PERIOD-1 while enabled.
// bit_tick is registered and lines up with the last count.
module fsk_bit_timer
  import fsk_pkg::*;
#(
  parameter int BIT_PERIOD = 400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             bit_tick
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] PRE_LAST =
    CNT_W'(BIT_PERIOD - 2);

  // Tick is set one count early so it is high exactly at LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bit_tick <= 1'b0;
    end else if (clr) begin
      cnt      <= '0;
      bit_tick <= 1'b0;
    end else if (en) begin
      cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
      bit_tick <= (cnt == PRE_LAST);
    end
  end

endmodule

// File: rtl/fsk_tx_sequencer.sv
// Frame controller ahead of the FSK modulator:
// preamble, start, LSB-first data, stop; modulator held in reset when idle.
module fsk_tx_sequencer
  import fsk_pkg::*;
#(
  parameter int BIT_PERIOD    = 400,
  parameter int PREAMBLE_BITS = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic              clk,
  input  logic              rst,
  fsk_tx_sequencer_if.slave tx,
  output logic              fsk_data,
  output logic              mod_rst,
  output logic              busy,
  output logic              bit_tick,
  output logic              frame_done
);

  localparam logic [CNT_W-1:0] PRE_LAST =
    CNT_W'(BIT_PERIOD - 2);
  localparam logic [3:0] PRE_END  =
    4'(PREAMBLE_BITS - 1);
  localparam logic [3:0] DATA_END =
    4'(DATA_BITS - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nx;
  logic                 run;
  logic                 ready;
  logic                 accept;

  assign run         = (state != IDLE);
  assign shreg_nx    = shreg >> 1;
  assign ready       = (state == IDLE) |
                       ((state == STOP) & bit_tick);
  assign tx.tx_ready = ready;
  assign accept      = tx.tx_valid & ready;

  fsk_bit_timer #(
    .BIT_PERIOD (BIT_PERIOD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (run),
    .clr      (~run),
    .cnt      (cnt),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fsk_data   <= MARK;
      mod_rst    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bit_idx    <= '0;
      shreg      <= '0;
    end else begin
      // Registered so it rises with the STOP symbol's bit_tick.
      frame_done <= (state == STOP) && (cnt == PRE_LAST);
      unique case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= tx.tx_data;
            mod_rst <= 1'b0;
            busy    <= 1'b1;
            bit_idx <= '0;
            if (PREAMBLE_BITS != 0) begin
              state    <= PRE;
              fsk_data <= MARK;
            end else begin
              state    <= START;
              fsk_data <= SPACE;
            end
          end
        end
        PRE: begin
          if (bit_tick) begin
            if (bit_idx == PRE_END) begin
              state    <= START;
              fsk_data <= SPACE;
              bit_idx  <= '0;
            end else begin
              fsk_data <= bit_idx[0];
              bit_idx  <= bit_idx + 1'b1;
            end
          end
        end
        START: begin
          if (bit_tick) begin
            state    <= DATA;
            fsk_data <= shreg[0];
            bit_idx  <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            shreg <= shreg_nx;
            if (bit_idx == DATA_END) begin
              state    <= STOP;
              fsk_data <= MARK;
              bit_idx  <= '0;
            end else begin
              fsk_data <= shreg_nx[0];
              bit_idx  <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            bit_idx <= '0;
            if (accept) begin
              state    <= START;
              shreg    <= tx.tx_data;
              fsk_data <= SPACE;
            end else begin
              state    <= IDLE;
              fsk_data <= MARK;
              mod_rst  <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          fsk_data <= MARK;
          mod_rst  <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
